stream_demux4: RTL and testbench

- 1:4 stream demultiplexer: routes a valid/ready input stream to one of four output streams, selected by a 2-bit select.
- The select is held for a whole packet (first beat to `in_last`).
- Each output has a 2-entry skid buffer, so throughput is one beat per cycle and outputs are registered.
- Counterpart to the generic Mux4 gate. Sel-to-port mapping mirrors Mux4: sel 3→out1, 2→out2, 1→out3, 0→out4.

---
 rtl/stream_demux_pkg.sv | 17 +
 rtl/stream_skid2.sv | 63 ++++++
 rtl/stream_demux4.sv | 156 +++++++++++++++
 tb/tb_stream_demux4.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the stream demultiplexer.
//   route_state_e : route FSM state (IDLE between packets, LOCKED mid-packet)
//   SEL_OUTn      : select value that steers a packet to output n
package stream_demux_pkg;

  typedef enum logic [0:0] {
    IDLE,
    LOCKED
  } route_state_e;

  // Mapping mirrors the Mux4 gate: highest select drives the first port.
  localparam logic [1:0] SEL_OUT1 = 2'd3;
  localparam logic [1:0] SEL_OUT2 = 2'd2;
  localparam logic [1:0] SEL_OUT3 = 2'd1;
  localparam logic [1:0] SEL_OUT4 = 2'd0;

endpackage

// File: rtl/stream_skid2.sv
// Two-entry FIFO holding {last, data} beats for one output stream.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   push            : write one beat (ignored while full)
//   push_data/last  : beat written on push
//   full            : both entries occupied (registered count only)
//   pop_ready       : downstream accepts head this cycle
//   head_valid      : head entry present
//   head_data/last  : entry at the read pointer (stale when empty)
module stream_skid2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_last,
  output logic             full,
  input  logic             pop_ready,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic             head_last
);

  logic [WIDTH:0] mem_q [2];
  logic           wr_ptr_q, rd_ptr_q;
  logic [1:0]     cnt_q, cnt_d;
  logic           do_push, do_pop;

  assign full       = (cnt_q == 2'd2);
  assign head_valid = (cnt_q != 2'd0);
  assign do_push    = push & ~full;
  assign do_pop     = head_valid & pop_ready;

  assign {head_last, head_data} = mem_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Payload storage needs no reset: it is only observed while count is nonzero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= {push_last, push_data};
  end

endmodule

// File: rtl/stream_demux4.sv
// 1:4 valid/ready stream demultiplexer with packet-level route locking.
// The select is sampled on the first beat of a packet and held until in_last.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   in_data/last/sel/valid    : input stream and route select
//   in_ready                  : routed buffer not full (never depends on outN_ready)
//   outN_data/last/valid      : head of output N buffer (N=1..4)
//   outN_ready                : downstream N accepts head
module stream_demux4
  import stream_demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_last,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out2_data,
  output logic             out2_last,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [WIDTH-1:0] out3_data,
  output logic             out3_last,
  output logic             out3_valid,
  input  logic             out3_ready,
  output logic [WIDTH-1:0] out4_data,
  output logic             out4_last,
  output logic             out4_valid,
  input  logic             out4_ready
);

  route_state_e state_q, state_d;
  logic [1:0]   route_q, route_d;
  logic [1:0]   route;
  logic         accept;
  logic         routed_full;
  logic [3:0]   full;  // bit n-1 belongs to output n
  logic [3:0]   push;

  assign route = (state_q == LOCKED) ? route_q : in_sel;

  always_comb begin
    routed_full = 1'b1;
    unique case (route)
      SEL_OUT1: routed_full = full[0];
      SEL_OUT2: routed_full = full[1];
      SEL_OUT3: routed_full = full[2];
      SEL_OUT4: routed_full = full[3];
      default:  routed_full = 1'b1;
    endcase
  end

  // Held low during reset so nothing is accepted into buffers being cleared.
  assign in_ready = ~rst & ~routed_full;
  assign accept   = in_valid & in_ready;

  always_comb begin
    push = 4'b0000;
    if (accept) begin
      unique case (route)
        SEL_OUT1: push = 4'b0001;
        SEL_OUT2: push = 4'b0010;
        SEL_OUT3: push = 4'b0100;
        SEL_OUT4: push = 4'b1000;
        default:  push = 4'b0000;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    route_d = route_q;
    unique case (state_q)
      IDLE: begin
        if (accept && !in_last) begin
          state_d = LOCKED;
          route_d = in_sel;
        end
      end
      LOCKED: begin
        if (accept && in_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      route_q <= 2'd0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
    end
  end

  stream_skid2 #(.WIDTH(WIDTH)) u_skid1 (
    .clk       (clk),
    .rst       (rst),
    .push      (push[0]),
    .push_data (in_data),
    .push_last (in_last),
    .full      (full[0]),
    .pop_ready (out1_ready),
    .head_valid(out1_valid),
    .head_data (out1_data),
    .head_last (out1_last)
  );

  stream_skid2 #(.WIDTH(WIDTH)) u_skid2 (
    .clk       (clk),
    .rst       (rst),
    .push      (push[1]),
    .push_data (in_data),
    .push_last (in_last),
    .full      (full[1]),
    .pop_ready (out2_ready),
    .head_valid(out2_valid),
    .head_data (out2_data),
    .head_last (out2_last)
  );

  stream_skid2 #(.WIDTH(WIDTH)) u_skid3 (
    .clk       (clk),
    .rst       (rst),
    .push      (push[2]),
    .push_data (in_data),
    .push_last (in_last),
    .full      (full[2]),
    .pop_ready (out3_ready),
    .head_valid(out3_valid),
    .head_data (out3_data),
    .head_last (out3_last)
  );

  stream_skid2 #(.WIDTH(WIDTH)) u_skid4 (
    .clk       (clk),
    .rst       (rst),
    .push      (push[3]),
    .push_data (in_data),
    .push_last (in_last),
    .full      (full[3]),
    .pop_ready (out4_ready),
    .head_valid(out4_valid),
    .head_data (out4_data),
    .head_last (out4_last)
  );

endmodule

// File: tb/tb_stream_demux4.sv
// Scoreboard bench for stream_demux4: each accepted beat is queued on the
// output it must reach; a monitor pops and compares every output transfer.
module tb_stream_demux4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_last = 1'b0;
  logic [1:0] in_sel = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] odata [4];
  logic       olast [4];
  logic       ovld [4];
  logic       rdy [4];

  logic [8:0] exp_q [4][$];
  int         pops [4];
  int         n_total = 0;
  int         n_bad = 0;
  int         stall_cnt = 0;

  always #5 clk = ~clk;

  stream_demux4 #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out1_data (odata[0]),
    .out1_last (olast[0]),
    .out1_valid(ovld[0]),
    .out1_ready(rdy[0]),
    .out2_data (odata[1]),
    .out2_last (olast[1]),
    .out2_valid(ovld[1]),
    .out2_ready(rdy[1]),
    .out3_data (odata[2]),
    .out3_last (olast[2]),
    .out3_valid(ovld[2]),
    .out3_ready(rdy[2]),
    .out4_data (odata[3]),
    .out4_last (olast[3]),
    .out4_valid(ovld[3]),
    .out4_ready(rdy[3])
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // A transfer happens at the next rising edge when valid & ready hold at the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        if (ovld[k] && rdy[k]) begin
          check_eq($sformatf("out%0d_beat_expected", k + 1), {31'd0, exp_q[k].size() != 0}, 1);
          if (exp_q[k].size() != 0) begin
            check_eq($sformatf("out%0d_beat", k + 1), {23'd0, olast[k], odata[k]},
                     {23'd0, exp_q[k].pop_front()});
          end
          pops[k]++;
        end
      end
    end
  end

  // Drives one beat, holds it until accepted, and records where it must appear.
  task automatic send(input int port, input logic [1:0] sel, input logic [7:0] data,
                      input logic last);
    bit ok = 0;
    int waits = 0;
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = data;
    in_last  = last;
    while (!ok && waits < 100) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q[port].push_back({last, data});
        ok = 1;
      end else begin
        stall_cnt++;
      end
      @(posedge clk);
      waits++;
    end
    #1;
    in_valid = 1'b0;
    check_eq("beat_accepted", {31'd0, ok}, 1);
  endtask

  task automatic drain();
    int n = 0;
    for (int k = 0; k < 4; k++) rdy[k] = 1'b1;
    while (n < 50 && (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() +
                      exp_q[3].size()) != 0) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++)
      check_eq($sformatf("out%0d_drained", k + 1), exp_q[k].size(), 0);
  endtask

  initial begin
    int   p0 [4];
    time  t0;
    logic [7:0] held;
    for (int k = 0; k < 4; k++) begin
      rdy[k]  = 1'b1;
      pops[k] = 0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", {31'd0, in_ready}, 0);
    for (int k = 0; k < 4; k++)
      check_eq($sformatf("rst_out%0d_valid", k + 1), {31'd0, ovld[k]}, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_in_ready", {31'd0, in_ready}, 1);
    @(posedge clk);
    #1;

    // Single-beat routing with one-cycle latency
    send(0, 2'd3, 8'hA1, 1'b1);
    check_eq("lat_out1_valid", {31'd0, ovld[0]}, 1);
    check_eq("lat_out1_data", {24'd0, odata[0]}, 32'hA1);
    send(3, 2'd0, 8'hB2, 1'b1);
    check_eq("lat_out4_valid", {31'd0, ovld[3]}, 1);
    check_eq("lat_out4_data", {24'd0, odata[3]}, 32'hB2);
    drain();

    // Packet lock: select changes mid-packet are ignored
    send(1, 2'd2, 8'h10, 1'b0);
    send(1, 2'd0, 8'h11, 1'b0);
    send(1, 2'd0, 8'h12, 1'b1);
    drain();

    // Backpressure on out3
    rdy[2] = 1'b0;
    send(2, 2'd1, 8'h20, 1'b0);
    send(2, 2'd1, 8'h21, 1'b0);
    fork
      send(2, 2'd1, 8'h22, 1'b1);
      begin
        repeat (2) begin
          @(negedge clk);
          check_eq("full_in_ready", {31'd0, in_ready}, 0);
        end
        rdy[2] = 1'b1;
        #1;
        check_eq("no_comb_ready_path", {31'd0, in_ready}, 0);
        @(negedge clk);
        check_eq("ready_after_pop", {31'd0, in_ready}, 1);
      end
    join
    drain();

    // Isolation: a full out1 does not block a packet to out2
    rdy[0] = 1'b0;
    send(0, 2'd3, 8'h30, 1'b1);
    send(0, 2'd3, 8'h31, 1'b1);
    t0 = $time;
    send(1, 2'd2, 8'h40, 1'b0);
    send(1, 2'd1, 8'h41, 1'b0);
    send(1, 2'd3, 8'h42, 1'b1);
    check_eq("iso_cycles", 32'($time - t0), 30);
    check_eq("iso_out1_valid", {31'd0, ovld[0]}, 1);
    held = odata[0];
    check_eq("iso_out1_data", {24'd0, held}, 32'h30);
    drain();

    // Throughput: 16 back-to-back single-beat packets
    stall_cnt = 0;
    for (int k = 0; k < 4; k++) p0[k] = pops[k];
    for (int i = 0; i < 16; i++)
      send(i % 4, 2'(3 - (i % 4)), 8'(8'h50 + i), 1'b1);
    check_eq("tput_stalls", stall_cnt, 0);
    drain();
    for (int k = 0; k < 4; k++)
      check_eq($sformatf("tput_out%0d_count", k + 1), pops[k] - p0[k], 4);

    // Reset mid-packet with out2 full
    rdy[1] = 1'b0;
    send(1, 2'd2, 8'h60, 1'b0);
    send(1, 2'd2, 8'h61, 1'b0);
    check_eq("pre_rst_out2_valid", {31'd0, ovld[1]}, 1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_in_ready", {31'd0, in_ready}, 0);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("async_rst_out%0d_valid", k + 1), {31'd0, ovld[k]}, 0);
      exp_q[k].delete();
      rdy[k] = 1'b1;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rel_in_ready", {31'd0, in_ready}, 1);
    repeat (3) @(posedge clk);
    #1;
    // Lock must be gone: sel=3 goes to out1, not to the old out2 route
    send(0, 2'd3, 8'h70, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
